instr_fetch_unit: RTL and testbench

//  Supplies 19-bit instruction words to the decode Controller and owns the PC.

---
 rtl/instr_fetch_unit_pkg.sv | 35 +++
 rtl/instr_fetch_unit_chk.sv | 19 +
 rtl/instr_fetch_unit_fetch_buffer.sv | 63 ++++++
 rtl/instr_fetch_unit.sv | 150 +++++++++++++++
 tb/tb_instr_fetch_unit.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit: FSM states,
// PC-source encodings, opcode field geometry and the PC-source priority helper.
package instr_fetch_unit_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } fetch_state_t;

  typedef enum logic [1:0] {
    PC_SRC_PLUS1  = 2'd0,
    PC_SRC_OFFSET = 2'd1,
    PC_SRC_CONST  = 2'd2
  } pc_src_t;

  // Opcode occupies the top OPCODE_W bits of an instruction word.
  localparam int OPCODE_W = 6;

  function automatic int opcode_lsb(input int instr_w);
    return instr_w - OPCODE_W;
  endfunction

  // const beats offset beats plus1; plus1 is also the fallback when nothing is selected.
  function automatic pc_src_t pc_src_sel(input logic sel_const, input logic sel_offset);
    if (sel_const) begin
      return PC_SRC_CONST;
    end else if (sel_offset) begin
      return PC_SRC_OFFSET;
    end else begin
      return PC_SRC_PLUS1;
    end
  endfunction

endpackage

// File: rtl/instr_fetch_unit_chk.sv
// Invariant checker for the fetch unit's credit accounting: in-flight requests
// plus buffered words may never exceed the two buffer slots.
module instr_fetch_unit_chk (
  input logic       clk,
  input logic       rst,
  input logic [1:0] outst,
  input logic [1:0] buf_count,
  input logic       push,
  input logic       pop,
  input logic       full
);

  a_outst_max: assert property (@(posedge clk) disable iff (rst) outst <= 2'd2);
  a_count_max: assert property (@(posedge clk) disable iff (rst) buf_count <= 2'd2);
  a_credit:    assert property (@(posedge clk) disable iff (rst)
                 ({1'b0, outst} + {1'b0, buf_count}) <= 3'd2);
  a_no_drop:   assert property (@(posedge clk) disable iff (rst) !(push && full && !pop));

endmodule

// File: rtl/instr_fetch_unit_fetch_buffer.sv
// Two-entry FIFO holding {instruction, pc} pairs between imem and decode.
// Push and pop may occur together; clear drops every entry.
module instr_fetch_unit_fetch_buffer
  import instr_fetch_unit_pkg::*;
#(
  parameter int W = 31
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         clear,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic [1:0]   count,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] mem_r [2];
  logic         wr_ptr_r;
  logic         rd_ptr_r;
  logic [1:0]   count_r;
  logic         do_push_s;
  logic         do_pop_s;

  assign do_pop_s  = pop && (count_r != 2'd0);
  assign do_push_s = push && ((count_r != 2'd2) || do_pop_s);

  assign rdata = mem_r[rd_ptr_r];
  assign count = count_r;
  assign full  = (count_r == 2'd2);
  assign empty = (count_r == 2'd0);

  // Storage, pointers and occupancy; clear keeps storage, only pointers/count reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_r[0] <= {W{1'b0}};
      mem_r[1] <= {W{1'b0}};
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else if (clear) begin
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= wdata;
        wr_ptr_r        <= ~wr_ptr_r;
      end
      if (do_pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues in-order imem requests, buffers
// responses for decode and flushes/redirects on taken jumps.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int              PC_W      = 12,
  parameter int              INSTR_W   = 19,
  parameter int              OFF_W     = 8,
  parameter int              MAX_OUTST = 2,
  parameter logic [PC_W-1:0] RESET_PC  = {PC_W{1'b0}}
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    instr_pc,
  input  logic               sel_pc_plus1,
  input  logic               sel_pc_offset,
  input  logic               sel_pc_const,
  input  logic               cond_taken,
  input  logic [OFF_W-1:0]   jmp_offset,
  input  logic [PC_W-1:0]    jmp_target
);

  localparam int              ENTRY_W     = INSTR_W + PC_W;
  localparam logic [1:0]      MAX_OUTST_C = 2'(MAX_OUTST);
  localparam logic [PC_W-1:0] PC_ONE      = {{(PC_W-1){1'b0}}, 1'b1};

  fetch_state_t       state_r, state_nxt_s;
  logic [PC_W-1:0]    fetch_pc_r, target_r, target_s, rsp_pc_s, off_sext_s;
  logic [1:0]         outst_r, buf_count_s;
  logic [2:0]         occupancy_s;
  logic [ENTRY_W-1:0] head_s, push_entry_s;
  logic               buf_full_s, buf_empty_s;
  logic               consume_s, redirect_s, req_fire_s, push_s, pop_s, room_s;
  logic               plus1_unused_s;
  pc_src_t            pc_src_s;

  // plus1 is also the fallback choice, so its level never changes the outcome.
  assign plus1_unused_s = sel_pc_plus1;

  assign instr_valid  = (state_r == RUN) && !buf_empty_s;
  assign instr        = head_s[ENTRY_W-1 -: INSTR_W];
  assign instr_pc     = head_s[PC_W-1:0];
  assign imem_addr    = fetch_pc_r;
  assign consume_s    = instr_valid && instr_ready;
  assign pc_src_s     = pc_src_sel(sel_pc_const, sel_pc_offset);
  assign redirect_s   = consume_s && ((pc_src_s == PC_SRC_CONST) ||
                                      ((pc_src_s == PC_SRC_OFFSET) && cond_taken));
  assign pop_s        = consume_s && !redirect_s;
  assign push_s       = imem_rsp_valid && (state_r == RUN) && !redirect_s;
  assign req_fire_s   = imem_req_valid && imem_req_ready;
  // Responses return in order, so the oldest in-flight request sits outst_r behind fetch_pc_r.
  assign rsp_pc_s     = fetch_pc_r - {{(PC_W-2){1'b0}}, outst_r};
  assign push_entry_s = {imem_rsp_data, rsp_pc_s};
  assign off_sext_s   = {{(PC_W-OFF_W){jmp_offset[OFF_W-1]}}, jmp_offset};
  // A slot freed by this cycle's pop is reusable now, which sustains one word per cycle.
  assign occupancy_s  = {1'b0, outst_r} + {1'b0, buf_count_s} - {2'b00, pop_s};
  assign room_s       = (occupancy_s < 3'd2) && (outst_r < MAX_OUTST_C);

  // Next-state and request-valid decode.
  always_comb begin
    state_nxt_s    = state_r;
    imem_req_valid = 1'b0;
    case (state_r)
      IDLE: state_nxt_s = RUN;
      RUN: begin
        imem_req_valid = room_s && !redirect_s;
        if (redirect_s) begin
          state_nxt_s = FLUSH;
        end else begin
          state_nxt_s = RUN;
        end
      end
      FLUSH: begin
        if (outst_r == 2'd0) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = FLUSH;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Redirect target adder.
  always_comb begin
    target_s = jmp_target;
    if (pc_src_s == PC_SRC_CONST) begin
      target_s = jmp_target;
    end else begin
      target_s = instr_pc + off_sext_s;
    end
  end

  // State, fetch PC, latched redirect target and in-flight request counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      fetch_pc_r <= RESET_PC;
      target_r   <= RESET_PC;
      outst_r    <= 2'd0;
    end else begin
      state_r <= state_nxt_s;
      if ((state_r == FLUSH) && (outst_r == 2'd0)) begin
        fetch_pc_r <= target_r;
      end else if (req_fire_s) begin
        fetch_pc_r <= fetch_pc_r + PC_ONE;
      end
      if (redirect_s) begin
        target_r <= target_s;
      end
      case ({req_fire_s, imem_rsp_valid})
        2'b10:   outst_r <= outst_r + 2'd1;
        2'b01:   outst_r <= outst_r - 2'd1;
        default: outst_r <= outst_r;
      endcase
    end
  end

  instr_fetch_unit_fetch_buffer #(.W(ENTRY_W)) u_buf (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (pop_s),
    .clear (redirect_s),
    .wdata (push_entry_s),
    .rdata (head_s),
    .count (buf_count_s),
    .full  (buf_full_s),
    .empty (buf_empty_s)
  );

  instr_fetch_unit_chk u_chk (
    .clk       (clk),
    .rst       (rst),
    .outst     (outst_r),
    .buf_count (buf_count_s),
    .push      (push_s),
    .pop       (pop_s),
    .full      (buf_full_s)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: memory and decode models, expected PC stream
// derived from the jump rules, directed scenarios then a randomized run.
module tb_instr_fetch_unit;

  localparam int PC_W = 12;
  localparam int INSTR_W = 19;
  localparam int OFF_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic [PC_W-1:0] imem_addr, instr_pc, jmp_target;
  logic [INSTR_W-1:0] imem_rsp_data, instr;
  logic instr_valid, instr_ready;
  logic sel_pc_plus1, sel_pc_offset, sel_pc_const, cond_taken;
  logic [OFF_W-1:0] jmp_offset;

  always #5 clk = ~clk;

  instr_fetch_unit dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
    .sel_pc_plus1(sel_pc_plus1), .sel_pc_offset(sel_pc_offset), .sel_pc_const(sel_pc_const),
    .cond_taken(cond_taken), .jmp_offset(jmp_offset), .jmp_target(jmp_target)
  );

  typedef struct { logic [PC_W-1:0] addr; int cyc; } req_t;
  typedef struct { logic [PC_W-1:0] pc; int kind; logic [PC_W-1:0] tgt; logic [OFF_W-1:0] off; } plan_t;

  req_t  pend[$];
  plan_t plan[$];
  int checks = 0, errors = 0, cyc_cnt = 0, consumes = 0, held = 0, dec_mode = 0, c0 = 0;
  bit mem_rand = 1'b0, sel_rand = 1'b0, stall_chk = 1'b0, flush_chk = 1'b0;
  logic [PC_W-1:0] exp_pc = 12'h000, exp_req = 12'h000;

  // Memory contents: a distinct, easily recomputed word per address.
  function automatic logic [INSTR_W-1:0] mem_word(input logic [PC_W-1:0] a);
    logic [INSTR_W-1:0] w;
    w = {a[5:0] ^ 6'h2B, a ^ 12'hA5C, 1'b1};
    return w;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive memory/decode after the falling edge, sample, score, advance.
  task automatic cycle();
    bit rsp_fire, req_fire, consume, redir, use_plan;
    logic [PC_W-1:0] nxt;
    int soff;
    if (rst) begin
      pend.delete();
      imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 19'h00000;
      instr_ready = 1'b0; sel_pc_plus1 = 1'b0; sel_pc_offset = 1'b0; sel_pc_const = 1'b0;
      cond_taken = 1'b0; jmp_offset = 8'h00; jmp_target = 12'h000;
      exp_pc = 12'h000; exp_req = 12'h000; held = 0; flush_chk = 1'b0;
    end else begin
      imem_req_ready = mem_rand ? ($urandom_range(2) != 0) : 1'b1;
      rsp_fire = (pend.size() > 0) && (pend[0].cyc < cyc_cnt) && (!mem_rand || $urandom_range(1) == 0);
      imem_rsp_valid = rsp_fire;
      imem_rsp_data = rsp_fire ? mem_word(pend[0].addr) : INSTR_W'($urandom);
      case (dec_mode)
        0:       instr_ready = 1'b1;
        1:       instr_ready = 1'($urandom_range(1));
        default: instr_ready = 1'b0;
      endcase
      jmp_target = PC_W'($urandom);
      jmp_offset = OFF_W'($urandom);
      if (sel_rand) begin
        sel_pc_const  = ($urandom_range(9) == 0);
        sel_pc_offset = ($urandom_range(4) == 0);
        cond_taken    = 1'($urandom_range(1));
        sel_pc_plus1  = 1'($urandom_range(1));
      end else begin
        sel_pc_const = 1'b0; sel_pc_offset = 1'b0; cond_taken = 1'b0; sel_pc_plus1 = 1'b1;
      end
      #1;
      use_plan = (plan.size() > 0) && instr_valid && (instr_pc == plan[0].pc);
      if (use_plan) begin
        jmp_target = plan[0].tgt; jmp_offset = plan[0].off;
        sel_pc_const = 1'b0; sel_pc_offset = 1'b0; cond_taken = 1'b0; sel_pc_plus1 = 1'b0;
        case (plan[0].kind)
          1: sel_pc_const = 1'b1;
          2: begin sel_pc_offset = 1'b1; cond_taken = 1'b1; end
          3: sel_pc_offset = 1'b1;
          4: begin sel_pc_const = 1'b1; sel_pc_offset = 1'b1; cond_taken = 1'b1; sel_pc_plus1 = 1'b1; end
          5: begin sel_pc_offset = 1'b1; cond_taken = 1'b1; sel_pc_plus1 = 1'b1; end
          default: ;
        endcase
      end
      #1;
      if (flush_chk) begin
        check("flush_instr_valid", 32'(instr_valid), 32'(1'b0));
        flush_chk = 1'b0;
      end
      if (stall_chk && !instr_ready)
        check("stall_req_valid", 32'(imem_req_valid), 32'(held < 2));
      req_fire = imem_req_valid && imem_req_ready;
      consume  = instr_valid && instr_ready;
      if (req_fire) begin
        check("req_addr", 32'(imem_addr), 32'(exp_req));
        exp_req = exp_req + 12'h001;
        pend.push_back('{addr: imem_addr, cyc: cyc_cnt});
        held++;
      end
      if (rsp_fire) void'(pend.pop_front());
      if (consume) begin
        consumes++;
        check("instr_pc", 32'(instr_pc), 32'(exp_pc));
        check("instr_word", 32'(instr), 32'(mem_word(exp_pc)));
        soff = int'($signed(jmp_offset));
        if (sel_pc_const) begin
          redir = 1'b1; nxt = jmp_target;
        end else if (sel_pc_offset && cond_taken) begin
          redir = 1'b1; nxt = PC_W'((int'(exp_pc) + soff + 4096) % 4096);
        end else begin
          redir = 1'b0; nxt = PC_W'((int'(exp_pc) + 1) % 4096);
        end
        if (use_plan) void'(plan.pop_front());
        if (redir) begin
          check("redirect_req_blocked", 32'(imem_req_valid), 32'(1'b0));
          exp_req = nxt; held = 0; flush_chk = 1'b1;
        end else begin
          held--;
        end
        exp_pc = nxt;
      end
    end
    @(posedge clk);
    cyc_cnt++;
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_valid"}, 32'(imem_req_valid), 32'(1'b0));
    check({tag, "_instr_valid"}, 32'(instr_valid), 32'(1'b0));
    check({tag, "_imem_addr"}, 32'(imem_addr), 32'(12'h000));
    check({tag, "_instr"}, 32'(instr), 32'(19'h00000));
    check({tag, "_instr_pc"}, 32'(instr_pc), 32'(12'h000));
  endtask

  initial begin
    @(negedge clk);
    repeat (3) cycle();
    check_reset_outputs("reset");
    rst = 1'b0;
    check("idle_no_req", 32'(imem_req_valid), 32'(1'b0));
    cycle();
    check("first_req", 32'(imem_req_valid), 32'(1'b1));

    // Sequential stream at full rate.
    repeat (10) cycle();
    c0 = consumes;
    repeat (20) cycle();
    check("throughput", 32'(consumes - c0), 32'd20);

    // Decode stall: requests stop once two words are owed.
    stall_chk = 1'b1; dec_mode = 2;
    repeat (5) cycle();
    stall_chk = 1'b0; dec_mode = 0;
    repeat (10) cycle();

    // Jump chain from a fresh reset, ending in the PC wrap.
    plan.push_back('{pc: 12'h003, kind: 1, tgt: 12'h040, off: 8'h00});
    plan.push_back('{pc: 12'h045, kind: 1, tgt: 12'h00E, off: 8'h00});
    plan.push_back('{pc: 12'h010, kind: 2, tgt: 12'h000, off: 8'hFC});
    plan.push_back('{pc: 12'h010, kind: 3, tgt: 12'h000, off: 8'hFC});
    plan.push_back('{pc: 12'h012, kind: 4, tgt: 12'h100, off: 8'h20});
    plan.push_back('{pc: 12'h102, kind: 5, tgt: 12'h7FF, off: 8'h05});
    plan.push_back('{pc: 12'h108, kind: 6, tgt: 12'h300, off: 8'h40});
    plan.push_back('{pc: 12'h10A, kind: 1, tgt: 12'hFFD, off: 8'h00});
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    for (int i = 0; i < 600 && plan.size() > 0; i++) cycle();
    check("plans_done", 32'(plan.size()), 32'd0);
    c0 = consumes;
    repeat (8) cycle();
    check("wrap_progress", 32'(consumes - c0 >= 5), 32'(1'b1));
    check("wrap_pc_low", 32'(exp_pc < 12'h010), 32'(1'b1));

    // Reset with the buffer full and requests possibly in flight.
    dec_mode = 2;
    repeat (4) cycle();
    rst = 1'b1;
    cycle();
    check_reset_outputs("midrst");
    rst = 1'b0;
    cycle();
    dec_mode = 0;
    c0 = consumes;
    repeat (20) cycle();
    check("restart_progress", 32'(consumes - c0 >= 15), 32'(1'b1));

    // Randomized memory timing, decode readiness and jump selects.
    mem_rand = 1'b1; sel_rand = 1'b1; dec_mode = 1;
    c0 = consumes;
    repeat (3000) cycle();
    check("random_progress", 32'(consumes - c0 > 100), 32'(1'b1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
